// File: rtl/clk_scaler_pkg.sv
// Shared types and constants for the clk_scaler block.
// Latency: none; declarations only.
// Backpressure: none.
//
// Contents:
//   state_t  - measurement/generation FSM states (IDLE, MEASURE, RUN)
//   MODE_MUL - mode value: multiply frequency (scaled period = period >> n)
//   MODE_DIV - mode value: divide frequency (scaled period = period << n, saturated)
package clk_scaler_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    RUN     = 2'd2
  } state_t;

  localparam logic MODE_MUL = 1'b0;
  localparam logic MODE_DIV = 1'b1;

endpackage

// File: rtl/clk_scaler_edge.sv
// Brings in_sig into the ref_clk domain and flags its rising edges.
// Latency: rise is seen by downstream state 2 cycles after the in_sig edge
//          (3 cycles when CLK_SCALER_SYNC_EN is defined).
// Backpressure: none; rise is a single-cycle strobe.
//
// Ports:
//   ref_clk - clock
//   rst     - synchronous active-high reset, clears all flops
//   in_sig  - asynchronous input being measured
//   rise    - one-cycle strobe, synchronised in_sig went 0 -> 1
//
// Build option: CLK_SCALER_SYNC_EN adds a second flop in front of the edge
// detector for metastability protection. The extra stage only delays the
// strobe; spacing between strobes (the measured period) is unchanged.
module clk_scaler_edge
  import clk_scaler_pkg::*;
(
  input  logic ref_clk,
  input  logic rst,
  input  logic in_sig,
  output logic rise
);

`ifdef CLK_SCALER_SYNC_EN
  logic sync_a;
  logic sync_b;
  logic sync_d;

  always_ff @(posedge ref_clk) begin
    if (rst) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
      sync_d <= 1'b0;
    end else begin
      sync_a <= in_sig;
      sync_b <= sync_a;
      sync_d <= sync_b;
    end
  end
`else
  logic sync_b;
  logic sync_d;

  always_ff @(posedge ref_clk) begin
    if (rst) begin
      sync_b <= 1'b0;
      sync_d <= 1'b0;
    end else begin
      sync_b <= in_sig;
      sync_d <= sync_b;
    end
  end
`endif

  // sync_d is sync_b one cycle late, so this is high for exactly one cycle
  // per low-to-high transition.
  assign rise = sync_b & ~sync_d;

endmodule

// File: rtl/clk_scaler.sv
// Measures the period of in_sig and regenerates a square wave at 2^n times
// (mode 0) or 1/2^n times (mode 1) its frequency.
// Latency: period updates on the rise strobe; out_sig changes follow the
//          half-period timer. Backpressure: none.
//
// Ports:
//   ref_clk      - clock, all state updates on its rising edge
//   rst          - synchronous active-high reset
//   in_sig       - signal being measured (asynchronous)
//   en           - enables out_sig generation; measurement always runs
//   mode         - MODE_MUL: period >> n, MODE_DIV: period << n (saturated)
//   n            - scale exponent
//   out_sig      - generated square wave
//   period       - last measured in_sig period in ref_clk cycles
//   period_valid - period holds a valid measurement
//   overflow     - sticky, in_sig period exceeded the counter range
//
// Build option: CLK_SCALER_SYNC_EN selects a two-flop input synchroniser
// (see clk_scaler_edge).
module clk_scaler
  import clk_scaler_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int SHIFT_W = 3
) (
  input  logic               ref_clk,
  input  logic               rst,
  input  logic               in_sig,
  input  logic               en,
  input  logic               mode,
  input  logic [SHIFT_W-1:0] n,
  output logic               out_sig,
  output logic [CNT_W-1:0]   period,
  output logic               period_valid,
  output logic               overflow
);

  // Wide enough to hold period shifted left by the largest n without loss,
  // so saturation can be decided by a plain compare.
  localparam int WIDE_W = CNT_W + (1 << SHIFT_W);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_t state;
  state_t state_nxt;

  logic             rise;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] timer;
  logic [CNT_W-1:0] timer_cur;
  logic             meas_done;
  logic             ovf_evt;
  logic             run_act;
  logic             armed;

  logic [WIDE_W-1:0] period_wide;
  logic [WIDE_W-1:0] shl_wide;
  logic [CNT_W-1:0]  scaled;
  logic [CNT_W-1:0]  half;

  clk_scaler_edge u_edge (
    .ref_clk (ref_clk),
    .rst     (rst),
    .in_sig  (in_sig),
    .rise    (rise)
  );

  // ---------------------------------------------------------------------
  // Scaled period and half-period reload value
  // ---------------------------------------------------------------------
  always_comb begin
    period_wide = WIDE_W'(period);
    shl_wide    = period_wide << n;
    scaled      = '0;
    if (mode == MODE_MUL) begin
      scaled = period >> n;
    end else if (shl_wide > WIDE_W'(CNT_MAX)) begin
      scaled = CNT_MAX;
    end else begin
      scaled = shl_wide[CNT_W-1:0];
    end
    // A half-period of zero would stall the timer; one cycle is the
    // fastest out_sig can toggle.
    half = scaled >> 1;
    if (half == '0) begin
      half = ONE;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge ref_clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next state and measurement strobes
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    meas_done = 1'b0;
    ovf_evt   = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          state_nxt = MEASURE;
        end
      end
      MEASURE, RUN: begin
        // A rise in the same cycle the counter saturates still counts as
        // a valid measurement, so rise is checked first.
        if (rise) begin
          state_nxt = RUN;
          meas_done = 1'b1;
        end else if (cnt == CNT_MAX) begin
          state_nxt = IDLE;
          ovf_evt   = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Period counter and measurement results
  // ---------------------------------------------------------------------
  always_ff @(posedge ref_clk) begin
    if (rst) begin
      cnt          <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rise) begin
            cnt <= ONE;
          end
        end
        MEASURE, RUN: begin
          if (meas_done) begin
            period       <= cnt;
            cnt          <= ONE;
            period_valid <= 1'b1;
          end else if (ovf_evt) begin
            cnt          <= '0;
            period_valid <= 1'b0;
            overflow     <= 1'b1;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        default: begin
          cnt <= '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Output generator
  // ---------------------------------------------------------------------
  assign run_act = (state == RUN) && en;

  // While idle the timer tracks half, but period is written on the same
  // edge that enters RUN, so the held value can be one measurement stale.
  // armed marks that the generator ran last cycle; on the first active
  // cycle the live half is used so the first toggle lands half cycles
  // after en is seen in RUN.
  assign timer_cur = armed ? timer : half;

  always_ff @(posedge ref_clk) begin
    if (rst) begin
      timer   <= '0;
      out_sig <= 1'b0;
      armed   <= 1'b0;
    end else if (ovf_evt || !run_act) begin
      timer   <= half;
      out_sig <= 1'b0;
      armed   <= 1'b0;
    end else begin
      armed <= 1'b1;
      // Reload only at a toggle, so changes to n, mode or period never
      // stretch or shorten the half-phase already in progress.
      if (timer_cur <= ONE) begin
        out_sig <= ~out_sig;
        timer   <= half;
      end else begin
        timer <= timer_cur - ONE;
      end
    end
  end

endmodule

// File: tb/tb_clk_scaler.sv
`timescale 1ns/1ps
module tb_clk_scaler;
  import clk_scaler_pkg::*;

  localparam int CNT_W   = 8;
  localparam int SHIFT_W = 3;

  logic               ref_clk = 1'b0;
  logic               rst     = 1'b1;
  logic               in_sig  = 1'b0;
  logic               en      = 1'b0;
  logic               mode    = 1'b0;
  logic [SHIFT_W-1:0] n       = '0;
  logic               out_sig;
  logic [CNT_W-1:0]   period;
  logic               period_valid;
  logic               overflow;

  int checks   = 0;
  int failures = 0;

  int gen_period = 0;   // 0 holds in_sig low
  bit mon_en     = 1'b0;
  int exp_q[$];         // expected out_sig half-phase lengths

  clk_scaler #(.CNT_W(CNT_W), .SHIFT_W(SHIFT_W)) dut (
    .ref_clk      (ref_clk),
    .rst          (rst),
    .in_sig       (in_sig),
    .en           (en),
    .mode         (mode),
    .n            (n),
    .out_sig      (out_sig),
    .period       (period),
    .period_valid (period_valid),
    .overflow     (overflow)
  );

  always #5 ref_clk = ~ref_clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cycles(input int k);
    repeat (k) @(negedge ref_clk);
  endtask

  task automatic do_reset();
    gen_period = 0;
    mon_en     = 1'b0;
    rst        = 1'b1;
    cycles(3);
    rst = 1'b0;
    cycles(1);
  endtask

  task automatic wait_valid(input string name);
    int k;
    k = 0;
    while (!period_valid && k < 2000) begin
      @(negedge ref_clk);
      k++;
    end
    check(name, int'(period_valid), 1);
  endtask

  // in_sig generator: periodic pulse train, high for about half the period.
  initial begin : gen
    int ph;
    int hi;
    ph = 0;
    forever begin
      @(posedge ref_clk);
      #1;
      if (gen_period == 0) begin
        in_sig = 1'b0;
        ph     = 0;
      end else begin
        hi     = (gen_period / 2 > 0) ? gen_period / 2 : 1;
        in_sig = (ph < hi);
        ph     = (ph + 1) % gen_period;
      end
    end
  end

  // Scoreboard consumer: measures each complete out_sig half-phase and
  // compares it with the next expected length. The first toggle after
  // enabling only starts timing.
  initial begin : mon
    bit   seg_on;
    int   seg_len;
    int   exp_len;
    logic last_out;
    seg_on   = 1'b0;
    seg_len  = 0;
    last_out = 1'b0;
    forever begin
      @(negedge ref_clk);
      if (!mon_en) begin
        seg_on   = 1'b0;
        seg_len  = 0;
        last_out = out_sig;
      end else begin
        seg_len++;
        if (out_sig != last_out) begin
          if (seg_on && exp_q.size() > 0) begin
            exp_len = exp_q.pop_front();
            check("seg_len", seg_len, exp_len);
          end
          seg_on   = 1'b1;
          seg_len  = 0;
          last_out = out_sig;
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

  typedef struct {
    int                 in_per;
    logic               md;
    logic [SHIFT_W-1:0] nn;
    int                 exp_period;
    int                 exp_half;
  } vec_t;

  vec_t vecs[7];

  initial begin : main
    int k;
    int len;
    logic prev;

    vecs[0] = '{20,  MODE_MUL, 3'd1, 20,  5};    // 20>>1=10
    vecs[1] = '{20,  MODE_DIV, 3'd2, 20,  40};   // 20<<2=80
    vecs[2] = '{20,  MODE_DIV, 3'd4, 20,  127};  // 320 -> 255
    vecs[3] = '{3,   MODE_MUL, 3'd3, 3,   1};    // 0 -> clamp 1
    vecs[4] = '{12,  MODE_MUL, 3'd0, 12,  6};
    vecs[5] = '{7,   MODE_DIV, 3'd1, 7,   7};    // 14
    vecs[6] = '{255, MODE_MUL, 3'd0, 255, 127};  // rise at saturation

    // Reset state
    cycles(3);
    check("rst_out_sig", int'(out_sig), 0);
    check("rst_period", int'(period), 0);
    check("rst_valid", int'(period_valid), 0);
    check("rst_overflow", int'(overflow), 0);

    // Table-driven frequency scaling
    for (int i = 0; i < 7; i++) begin
      do_reset();
      mode       = vecs[i].md;
      n          = vecs[i].nn;
      en         = 1'b1;
      gen_period = vecs[i].in_per;
      wait_valid($sformatf("v%0d_valid", i));
      check($sformatf("v%0d_period", i), int'(period), vecs[i].exp_period);
      check($sformatf("v%0d_overflow", i), int'(overflow), 0);
      repeat (4) exp_q.push_back(vecs[i].exp_half);
      mon_en = 1'b1;
      k = 0;
      while (exp_q.size() > 0 && k < 3000) begin
        cycles(1);
        k++;
      end
      check($sformatf("v%0d_drain", i), exp_q.size(), 0);
      mon_en = 1'b0;
      exp_q.delete();
    end

    // Overflow: in_sig stuck low after running
    do_reset();
    mode = MODE_MUL; n = 3'd1; en = 1'b1;
    gen_period = 20;
    wait_valid("ovf_pre_valid");
    gen_period = 0;
    cycles(300);
    check("ovf_flag", int'(overflow), 1);
    check("ovf_valid", int'(period_valid), 0);
    check("ovf_out_sig", int'(out_sig), 0);
    gen_period = 20;
    cycles(80);
    check("ovf_revalid", int'(period_valid), 1);
    check("ovf_sticky", int'(overflow), 1);

    // n change mid-phase: running half-phase keeps old length
    do_reset();
    mode = MODE_MUL; n = 3'd1; en = 1'b1;
    gen_period = 20;
    wait_valid("nchg_valid");
    cycles(25);
    k = 0;
    prev = out_sig;
    while (k < 200) begin
      @(negedge ref_clk);
      k++;
      if (out_sig && !prev) break;
      prev = out_sig;
    end
    check("nchg_align", int'(out_sig), 1);
    len = 0;
    while (out_sig == 1'b1 && len < 200) begin
      @(negedge ref_clk);
      len++;
      if (len == 2) n = 3'd0;
    end
    check("nchg_old_phase", len, 5);
    len = 0;
    while (out_sig == 1'b0 && len < 200) begin
      @(negedge ref_clk);
      len++;
    end
    check("nchg_new_phase", len, 10);

    // Reset mid-RUN
    n = 3'd1;
    cycles(7);
    rst = 1'b1;
    gen_period = 0;
    cycles(1);
    check("mrst_out_sig", int'(out_sig), 0);
    check("mrst_period", int'(period), 0);
    check("mrst_valid", int'(period_valid), 0);
    check("mrst_overflow", int'(overflow), 0);
    cycles(2);
    rst = 1'b0;
    gen_period = 20;
    cycles(15);
    check("mrst_one_rise", int'(period_valid), 0);
    cycles(15);
    check("mrst_two_rise", int'(period_valid), 1);
    check("mrst_period_new", int'(period), 20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clk_scaler.md
CLK_SCALER -- requirements
Module: clk_scaler

Interface
REQ-001 Parameter CNT_W, default 8: width of the period counter, scaled period and output timer.
REQ-002 Parameter SHIFT_W, default 3: width of the scale exponent n.
REQ-003 Port ref_clk  input  1: the single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1: reset, synchronous and active-high.
REQ-005 Port in_sig  input  1: signal to be measured, asynchronous to ref_clk.
REQ-006 Port en  input  1: enables output generation; measurement runs regardless.
REQ-007 Port mode  input  1: 0 = multiply frequency (period >> n), 1 = divide frequency (period << n).
REQ-008 Port n  input  SHIFT_W: scale exponent.
REQ-009 Port out_sig  output  1: generated square wave.
REQ-010 Port period  output  CNT_W: last measured in_sig period, in ref_clk cycles.
REQ-011 Port period_valid  output  1: period holds a valid measurement.
REQ-012 Port overflow  output  1: sticky; in_sig period exceeded 2^CNT_W-1 cycles.

Function
REQ-013 The block SHALL detect a rising edge ("rise") in the cycle where synchronised in_sig is 1 and its one-cycle-delayed copy is 0.
REQ-014 The FSM SHALL have states IDLE, MEASURE and RUN; reset enters IDLE.
REQ-015 IDLE: on rise, go to MEASURE with the period counter set to 1.
REQ-016 MEASURE/RUN: the counter SHALL increment each cycle without a rise; on rise, period <= counter value, the counter reloads 1, period_valid <= 1, and the state goes to RUN.
REQ-017 If the counter reaches 2^CNT_W-1 without a rise, the block SHALL set overflow, clear period_valid, force out_sig to 0 and return to IDLE.
REQ-018 Scaled period SHALL be period >> n when mode=0, and period << n saturated to 2^CNT_W-1 when mode=1.
REQ-019 Half-period SHALL be scaled period >> 1, clamped to a minimum of 1.
REQ-020 In RUN with en=1, the output timer SHALL count down from half-period; when it reaches 1, out_sig toggles and the timer reloads the current half-period.
REQ-021 A change in n, mode or period SHALL take effect only at the next out_sig toggle; the running half-phase completes unchanged.
REQ-022 With en=0, or in a state other than RUN, out_sig SHALL be 0 and the timer SHALL hold the half-period reload value; the first toggle occurs half-period cycles after en=1 is sampled in RUN.
REQ-023 A rise coinciding with counter saturation SHALL be treated as a rise: the measurement is valid and overflow is not set.
REQ-024 overflow SHALL clear only on rst.

Reset
REQ-025 On rst=1 at a clock edge: state=IDLE, counter=0, timer=0, period=0, period_valid=0, overflow=0, out_sig=0, and synchroniser flops=0.
REQ-026 Reset asserted mid-RUN SHALL discard the measurement; after release, a fresh rise is required before period_valid returns to 1.

Configuration
REQ-027 Macro CLK_SCALER_SYNC_EN defined: in_sig SHALL pass through a two-flop synchroniser before edge detection, giving a rise-detect latency of 3 cycles after the in_sig edge.
REQ-028 Macro CLK_SCALER_SYNC_EN undefined: in_sig SHALL be registered once, giving a latency of 2 cycles; measured periods are identical in both builds.

Structure
REQ-029 Package clk_scaler_pkg SHALL hold the FSM state enum (IDLE, MEASURE, RUN) and the mode constants MODE_MUL=0 and MODE_DIV=1.
REQ-030 Sub-module clk_scaler_edge SHALL contain the synchroniser (per the macro) and the rise detector, and SHALL output rise.

Verification
REQ-031 in_sig period 20 cycles, mode=0, n=1, en=1 -> period=20, period_valid=1 after the second rise; out_sig 5 high / 5 low.
REQ-032 in_sig period 20 cycles, mode=1, n=2 -> scaled period 80, out_sig 40 high / 40 low; with n=4, scaled period saturates to 255 and half-period is 127.
REQ-033 in_sig period 3 cycles, mode=0, n=3 -> scaled period 0, half-period clamped to 1; out_sig toggles every cycle.
REQ-034 in_sig held low for 300 cycles after one rise (CNT_W=8) -> overflow=1, period_valid=0, out_sig=0, state IDLE; overflow stays 1 after later valid rises.
REQ-035 n changed from 1 to 0 mid-phase -> current half-phase completes at the old length, and the next phase uses the new half-period.
REQ-036 rst asserted mid-RUN -> all outputs 0 the next cycle; period_valid=1 only after two new rises.
